// File: rtl/invmixcol_acc_if.sv
// Byte-in / column-out handshake bundle for the InvMixColumns accumulator.
// slave = accumulator side, master = upstream product stage plus downstream consumer.
interface invmixcol_acc_if;
  logic        clr;
  logic        in_vld;
  logic        in_rdy;
  logic [7:0]  x;
  logic [7:0]  p0e;
  logic [7:0]  p0b;
  logic [7:0]  p0d;
  logic [7:0]  p09;
  logic        out_vld;
  logic        out_rdy;
  logic [31:0] out_col;

  modport slave (
    input  clr, in_vld, x, p0e, p0b, p0d, p09, out_rdy,
    output in_rdy, out_vld, out_col
  );

  modport master (
    output clr, in_vld, x, p0e, p0b, p0d, p09, out_rdy,
    input  in_rdy, out_vld, out_col
  );
endinterface

// File: rtl/invmixcol_acc.sv
// Byte-serial InvMixColumns accumulator: 4 product bytes -> one 32-bit column, 1 clk latency.
// Single-entry output register; byte 3 stalls while a column is pending. AES_INVMIXCOL_BYPASS_EN adds `bypass`.
module invmixcol_acc (
  input  logic           clk,
  input  logic           rst_n,
`ifdef AES_INVMIXCOL_BYPASS_EN
  input  logic           bypass,
`endif
  invmixcol_acc_if.slave bus
);

  logic [1:0]       cnt_q, cnt_d;
  logic [0:3][7:0]  acc_q, acc_d;   // index 0 = row 0 = out_col[31:24]
  logic [0:3][7:0]  term;
  logic [31:0]      col_q, col_d;
  logic             vld_q, vld_d;
  logic             take, done;
  logic [7:0]       prod [4];

  assign prod[0] = bus.p0e;
  assign prod[1] = bus.p0b;
  assign prod[2] = bus.p0d;
  assign prod[3] = bus.p09;

`ifdef AES_INVMIXCOL_BYPASS_EN
  logic byp_q, byp_d, byp_cur;
  assign byp_cur = (cnt_q == 2'd0) ? bypass : byp_q;
`else
  logic unused_x;
  assign unused_x = ^bus.x;
`endif

  // Row r takes the product whose coefficient sits (i - r) mod 4 along {0e,0b,0d,09}.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      term[r] = prod[2'(cnt_q - 2'(r))];
`ifdef AES_INVMIXCOL_BYPASS_EN
      if (byp_cur) term[r] = (cnt_q == 2'(r)) ? bus.x : 8'h00;
`endif
    end
  end

  assign bus.in_rdy  = !(cnt_q == 2'd3 && vld_q && !bus.out_rdy);
  assign bus.out_vld = vld_q;
  assign bus.out_col = col_q;

  always_comb begin
    take  = bus.in_vld && bus.in_rdy;
    done  = take && !bus.clr && (cnt_q == 2'd3);
    cnt_d = cnt_q;
    acc_d = acc_q;
    col_d = col_q;
    vld_d = vld_q;
    if (bus.clr) begin
      cnt_d = 2'd0;
      acc_d = '0;
    end else if (take) begin
      cnt_d = cnt_q + 2'd1;
      acc_d = (cnt_q == 2'd0) ? term : (acc_q ^ term);
    end
    if (done) begin
      col_d = acc_q ^ term;
      vld_d = 1'b1;
    end else if (bus.out_rdy) begin
      vld_d = 1'b0;
    end
  end

`ifdef AES_INVMIXCOL_BYPASS_EN
  always_comb begin
    byp_d = byp_q;
    if (take && !bus.clr && cnt_q == 2'd0) byp_d = bypass;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) byp_q <= 1'b0;
    else        byp_q <= byp_d;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 2'd0;
      acc_q <= '0;
      col_q <= 32'h0;
      vld_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      col_q <= col_d;
      vld_q <= vld_d;
    end
  end

endmodule

// File: tb/tb_invmixcol_acc.sv
// Directed bench for invmixcol_acc: column-level InvMixColumns model plus literal column checks.
module tb_invmixcol_acc;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  invmixcol_acc_if bus();
`ifdef AES_INVMIXCOL_BYPASS_EN
  logic bypass = 1'b0;
`endif

  invmixcol_acc dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef AES_INVMIXCOL_BYPASS_EN
    .bypass(bypass),
`endif
    .bus   (bus)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  logic chk_en = 1'b0;
  logic [31:0] got_col [$];
  int          got_cyc [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Textbook InvMixColumns matrix applied to a column (row 0 in the MSB byte).
  function automatic logic [31:0] invmix(input logic [31:0] c);
    logic [7:0] m [4][4];
    logic [7:0] b [4];
    logic [7:0] o;
    logic [31:0] res;
    m[0] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    m[1] = '{8'h09, 8'h0e, 8'h0b, 8'h0d};
    m[2] = '{8'h0d, 8'h09, 8'h0e, 8'h0b};
    m[3] = '{8'h0b, 8'h0d, 8'h09, 8'h0e};
    for (int i = 0; i < 4; i++) b[i] = c[31-8*i -: 8];
    res = 32'h0;
    for (int r = 0; r < 4; r++) begin
      o = 8'h00;
      for (int i = 0; i < 4; i++) o = o ^ gmul(b[i], m[r][i]);
      res[31-8*r -: 8] = o;
    end
    return res;
  endfunction

  // Column-level reference: collect bytes, emit a column, track the single output slot.
  logic [1:0]  m_cnt;
  logic [7:0]  m_bytes [4];
  logic        m_byp;
  logic        m_vld;
  logic [31:0] m_col;
  logic        m_rdy;
  logic        m_bypass_in;

`ifdef AES_INVMIXCOL_BYPASS_EN
  assign m_bypass_in = bypass;
`else
  assign m_bypass_in = 1'b0;
`endif

  assign m_rdy = !(m_cnt == 2'd3 && m_vld && !bus.out_rdy);

  always @(posedge clk or negedge rst_n) begin
    logic take, done, use_byp;
    logic [31:0] raw;
    if (!rst_n) begin
      m_cnt <= 2'd0;
      m_byp <= 1'b0;
      m_vld <= 1'b0;
      m_col <= 32'h0;
    end else begin
      take = bus.in_vld && m_rdy && !bus.clr;
      done = take && (m_cnt == 2'd3);
      use_byp = m_byp;
      if (bus.clr) m_cnt <= 2'd0;
      else if (take) begin
        m_bytes[m_cnt] <= bus.x;
        m_cnt <= m_cnt + 2'd1;
        if (m_cnt == 2'd0) m_byp <= m_bypass_in;
      end
      if (done) begin
        raw = {m_bytes[0], m_bytes[1], m_bytes[2], bus.x};
        m_col <= use_byp ? raw : invmix(raw);
        m_vld <= 1'b1;
      end else if (bus.out_rdy) begin
        m_vld <= 1'b0;
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("in_rdy", 32'(bus.in_rdy), 32'(m_rdy));
      chk("out_vld", 32'(bus.out_vld), 32'(m_vld));
      if (m_vld) chk("out_col", bus.out_col, m_col);
      if (bus.out_vld && bus.out_rdy) begin
        got_col.push_back(bus.out_col);
        got_cyc.push_back(cyc);
      end
    end
  end

  task automatic drive(input logic [7:0] b);
    bus.x = b;
    bus.p0e = gmul(b, 8'h0e);
    bus.p0b = gmul(b, 8'h0b);
    bus.p0d = gmul(b, 8'h0d);
    bus.p09 = gmul(b, 8'h09);
    bus.in_vld = 1'b1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the byte is taken. in_vld stays high.
  task automatic send(input logic [7:0] b);
    logic ok;
    drive(b);
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = bus.in_rdy;
      @(posedge clk);
      #1;
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_col(input logic [31:0] c);
    for (int i = 0; i < 4; i++) send(c[31-8*i -: 8]);
  endtask

  task automatic idle();
    bus.in_vld = 1'b0;
  endtask

  task automatic expect_col(input string name, input logic [31:0] exp, output int c);
    for (int k = 0; k < 100 && got_col.size() == 0; k++) begin
      @(posedge clk);
      #1;
    end
    if (got_col.size() == 0) begin
      chk({name, "_timeout"}, 32'd0, 32'd1);
      c = -1;
    end else begin
      chk(name, got_col.pop_front(), exp);
      c = got_cyc.pop_front();
    end
  endtask

  initial begin
    int c1, c2;
    bus.clr = 1'b0;
    bus.in_vld = 1'b0;
    bus.x = 8'h00;
    bus.p0e = 8'h00;
    bus.p0b = 8'h00;
    bus.p0d = 8'h00;
    bus.p09 = 8'h00;
    bus.out_rdy = 1'b1;

    #12;
    chk("rst_out_vld", 32'(bus.out_vld), 32'd0);
    chk("rst_out_col", bus.out_col, 32'h0);
    chk("rst_in_rdy", 32'(bus.in_rdy), 32'd1);
    chk("model_pin_a", invmix(32'h8e4da1bc), 32'hdb135345);
    chk("model_pin_b", invmix(32'h9fdc589d), 32'hf20a225c);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Single column, downstream always ready: one-cycle valid pulse.
    send_col(32'h8e4da1bc);
    idle();
    chk("t1_vld_rise", 32'(bus.out_vld), 32'd1);
    @(posedge clk);
    #1;
    chk("t1_vld_pulse", 32'(bus.out_vld), 32'd0);
    expect_col("t1_col", 32'hdb135345, c1);

    // Back-to-back columns with in_vld held high.
    send_col(32'h9fdc589d);
    send_col(32'h01010101);
    idle();
    expect_col("t2_col_a", 32'hf20a225c, c1);
    expect_col("t2_col_b", 32'h01010101, c2);
    chk("t2_gap", 32'(c2 - c1), 32'd4);

    // Downstream stall: bytes 0-2 of the next column accepted, byte 3 held off.
    bus.out_rdy = 1'b0;
    send_col(32'h9fdc589d);
    send(8'h8e);
    send(8'h4d);
    send(8'ha1);
    drive(8'hbc);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("t3_stall_rdy", 32'(bus.in_rdy), 32'd0);
    chk("t3_held_col", bus.out_col, 32'hf20a225c);
    @(posedge clk);
    #1;
    bus.out_rdy = 1'b1;
    @(posedge clk);
    #1;
    idle();
    expect_col("t3_col_a", 32'hf20a225c, c1);
    expect_col("t3_col_b", 32'hdb135345, c2);
    chk("t3_gap", 32'(c2 - c1), 32'd1);

    // Abort after two bytes; the coinciding byte is dropped too.
    send(8'h11);
    send(8'h22);
    bus.clr = 1'b1;
    drive(8'h33);
    @(posedge clk);
    #1;
    bus.clr = 1'b0;
    idle();
    send_col(32'h8e4da1bc);
    idle();
    expect_col("t4_col", 32'hdb135345, c1);

    // Async reset mid-column with a column still pending.
    bus.out_rdy = 1'b0;
    send_col(32'h01010101);
    send(8'h9f);
    send(8'hdc);
    idle();
    chk("t5_pre_vld", 32'(bus.out_vld), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_vld", 32'(bus.out_vld), 32'd0);
    chk("t5_rst_col", bus.out_col, 32'h0);
    chk("t5_rst_rdy", 32'(bus.in_rdy), 32'd1);
    #2;
    bus.out_rdy = 1'b1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_col(32'h9fdc589d);
    idle();
    expect_col("t5_col", 32'hf20a225c, c1);

`ifdef AES_INVMIXCOL_BYPASS_EN
    // Bypass sampled on byte 0 only, held for the rest of the column.
    bypass = 1'b1;
    send(8'h11);
    bypass = 1'b0;
    send(8'h22);
    send(8'h33);
    send(8'h44);
    idle();
    expect_col("t6_bypass", 32'h11223344, c1);
    send_col(32'h8e4da1bc);
    idle();
    expect_col("t6_after", 32'hdb135345, c1);
`endif

    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk("no_extra_cols", 32'(got_col.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
